addsub_share_ctrl: RTL and testbench

ADDSUB_SHARE_CTRL -- requirements
Module: addsub_share_ctrl

---
 rtl/addsub_pkg.sv | 20 ++
 rtl/addsub_alu8.sv | 27 ++
 rtl/addsub_rr_arb.sv | 33 +++
 rtl/addsub_share_ctrl.sv | 133 +++++++++++++
 tb/tb_addsub_share_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the time-shared add/subtract controller: FSM encoding,
// opcodes, saturation limits and overflow counter ceiling.
package addsub_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [DATA_W-1:0] SAT_POS     = 8'h7F;
    localparam logic [DATA_W-1:0] SAT_NEG     = 8'h80;
    localparam logic [DATA_W-1:0] OVF_CNT_MAX = 8'hFF;

endpackage

// File: rtl/addsub_alu8.sv
// Combinational 8-bit two's-complement adder/subtractor with signed overflow
// flag (carry into MSB xor carry out of MSB).
module addsub_alu8
    import addsub_pkg::*;
(
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic                     op_i,
    output logic signed [DATA_W-1:0] s_o,
    output logic                     ovf_o
);

    logic [DATA_W-1:0] b_x;
    logic [DATA_W:0]   sum_full;
    logic [DATA_W-1:0] sum_low;

    always_comb begin
        b_x      = (op_i == OP_SUB) ? ~b_i : b_i;
        sum_full = {1'b0, a_i} + {1'b0, b_x} + {{DATA_W{1'b0}}, op_i};
        // Low bits alone expose the carry into the sign bit.
        sum_low  = {1'b0, a_i[DATA_W-2:0]} + {1'b0, b_x[DATA_W-2:0]}
                 + {{(DATA_W-1){1'b0}}, op_i};
        ovf_o    = sum_low[DATA_W-1] ^ sum_full[DATA_W];
        s_o      = sum_full[DATA_W-1:0];
    end

endmodule

// File: rtl/addsub_rr_arb.sv
// Two-way round-robin arbiter; the last-granted index moves only when the
// grant is actually consumed by an accept.
module addsub_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic accept_i,
    output logic grant_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        if (valid0_i && valid1_i) begin
            grant_o = ~last_q;
        end else begin
            grant_o = valid1_i;
        end
        last_d = accept_i ? grant_o : last_q;
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/addsub_share_ctrl.sv
// Two requesters share one adder/subtractor through an IDLE/EXEC/RESP FSM.
// Define ADDSUB_SAT_EN to saturate overflowed results instead of wrapping.
module addsub_share_ctrl
    import addsub_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_s,
    output logic       rsp_ovf,
    output logic [7:0] ovf_count
);

`ifdef ADDSUB_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] fmt_result(input logic [DATA_W-1:0] s,
                                                     input logic ovf,
                                                     input logic a_msb);
        // Overflow direction follows the sign of A for both add and subtract.
        if (SAT_EN && ovf) begin
            return a_msb ? SAT_NEG : SAT_POS;
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] cnt);
        return (cnt == OVF_CNT_MAX) ? cnt : cnt + 8'd1;
    endfunction

    state_e state_q, state_d;

    logic                     grant;
    logic                     accept;
    logic signed [DATA_W-1:0] a_q, b_q;
    logic                     op_q;
    logic                     id_q;
    logic signed [DATA_W-1:0] alu_s;
    logic                     alu_ovf;

    logic [DATA_W-1:0] rsp_s_q;
    logic              rsp_ovf_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] ovf_cnt_q;

    addsub_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .accept_i (accept),
        .grant_o  (grant)
    );

    assign req0_ready = (state_q == ST_IDLE) && !grant && req0_valid;
    assign req1_ready = (state_q == ST_IDLE) &&  grant && req1_valid;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_EXEC;
            ST_EXEC:                state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture stage: operands of the granted requester.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= grant ? req1_a  : req0_a;
            b_q  <= grant ? req1_b  : req0_b;
            op_q <= grant ? req1_op : req0_op;
            id_q <= grant;
        end
    end

    addsub_alu8 u_alu (
        .a_i   (a_q),
        .b_i   (b_q),
        .op_i  (op_q),
        .s_o   (alu_s),
        .ovf_o (alu_ovf)
    );

    // Result stage: loaded on the EXEC->RESP edge, held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_s_q   <= '0;
            rsp_ovf_q <= 1'b0;
            rsp_id_q  <= 1'b0;
            ovf_cnt_q <= '0;
        end else if (state_q == ST_EXEC) begin
            rsp_s_q   <= fmt_result(alu_s, alu_ovf, a_q[DATA_W-1]);
            rsp_ovf_q <= alu_ovf;
            rsp_id_q  <= id_q;
            if (alu_ovf) begin
                ovf_cnt_q <= sat_inc(ovf_cnt_q);
            end
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_s     = rsp_s_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_id    = rsp_id_q;
    assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Directed bench for addsub_share_ctrl with a transaction-level reference model
// checked every cycle; honours ADDSUB_SAT_EN for expected results.
module tb_addsub_share_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
    logic       req0_op = 1'b0, req1_op = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_id;
    logic [7:0] rsp_s;
    logic       rsp_ovf;
    logic [7:0] ovf_count;

    int checks = 0;
    int errors = 0;

`ifdef ADDSUB_SAT_EN
    localparam logic [7:0] X029 = 8'h80;
    localparam logic [7:0] X030 = 8'h7F;
`else
    localparam logic [7:0] X029 = 8'h7F;
    localparam logic [7:0] X030 = 8'h80;
`endif

    addsub_share_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_s      (rsp_s),
        .rsp_ovf    (rsp_ovf),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic on true signed integers.
    function automatic void model_op(input logic [7:0] a, input logic [7:0] b, input logic op,
                                     output logic [7:0] s, output logic o);
        int t;
        t = op ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        o = (t > 127) || (t < -128);
        s = t[7:0];
`ifdef ADDSUB_SAT_EN
        if (o) s = (t > 0) ? 8'h7F : 8'h80;
`endif
    endfunction

    // Transaction model: one operation in flight, response visible two cycles after accept.
    int         cyc = 0, acc_cyc = 0;
    bit         mdl_on = 0, inflight = 0, last_g = 1, rst_seen = 0;
    bit         g, er0, er1, ev;
    logic [7:0] e_s, cnt_m;
    logic       e_o, e_id;

    always @(negedge clk) begin
        cyc++;
        if (mdl_on) begin
            if (rst_seen) begin
                chk("reset_rsp_s", rsp_s, 0);
                chk("reset_rsp_ovf", rsp_ovf, 0);
                chk("reset_rsp_id", rsp_id, 0);
                rst_seen = 0;
            end
            g   = (req0_valid && req1_valid) ? !last_g : req1_valid;
            er0 = !inflight && !g && req0_valid;
            er1 = !inflight &&  g && req1_valid;
            chk("m_ready0", req0_ready, er0);
            chk("m_ready1", req1_ready, er1);
            ev = inflight && (cyc >= acc_cyc + 2);
            if (inflight && cyc == acc_cyc + 2 && e_o && cnt_m != 8'hFF) cnt_m++;
            chk("m_rsp_valid", rsp_valid, ev);
            if (ev) begin
                chk("m_rsp_s", rsp_s, e_s);
                chk("m_rsp_ovf", rsp_ovf, e_o);
                chk("m_rsp_id", rsp_id, e_id);
            end
            chk("m_ovf_count", ovf_count, cnt_m);
        end
        if (rst) begin
            mdl_on = 1; inflight = 0; last_g = 1; cnt_m = 8'h00; rst_seen = 1;
        end else if (mdl_on) begin
            if (ev && rsp_ready) inflight = 0;
            if (er0 || er1) begin
                inflight = 1;
                acc_cyc  = cyc;
                last_g   = g;
                e_id     = g;
                if (g) model_op(req1_a, req1_b, req1_op, e_s, e_o);
                else   model_op(req0_a, req0_b, req0_op, e_s, e_o);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_ovf_count", ovf_count, 0);
    endtask

    task automatic drive(input int n, input logic [7:0] a, input logic [7:0] b, input logic op);
        if (n == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        else        begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    endtask

    task automatic wait_ready(input int n, output bit got);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = (n == 0) ? req0_ready : req1_ready;
        end
        chk("accept_seen", got, 1);
    endtask

    task automatic run_one(input int n, input logic [7:0] a, input logic [7:0] b, input logic op,
                           input logic [7:0] xs, input logic xo, input string nm);
        bit got;
        @(posedge clk); #1 drive(n, a, b, op);
        wait_ready(n, got);
        @(posedge clk); #1 if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_exec_valid"}, rsp_valid, 0);
        @(negedge clk);
        chk({nm, "_valid"}, rsp_valid, 1);
        chk({nm, "_s"}, rsp_s, xs);
        chk({nm, "_ovf"}, rsp_ovf, xo);
        chk({nm, "_id"}, rsp_id, n);
    endtask

    logic [7:0] got_s  [2];
    logic       got_o  [2];
    logic       got_id [2];
    int         nresp;

    task automatic run_both(input logic [7:0] a0, input logic [7:0] b0, input logic op0,
                            input logic [7:0] a1, input logic [7:0] b1, input logic op1);
        bit d0, d1;
        d0 = 0; d1 = 0; nresp = 0;
        @(posedge clk); #1 drive(0, a0, b0, op0); drive(1, a1, b1, op1);
        repeat (20) begin
            @(negedge clk);
            if (req0_ready) d0 = 1;
            if (req1_ready) d1 = 1;
            if (rsp_valid && nresp < 2) begin
                got_s[nresp] = rsp_s; got_o[nresp] = rsp_ovf; got_id[nresp] = rsp_id;
                nresp++;
            end
            @(posedge clk); #1
            if (d0) req0_valid = 1'b0;
            if (d1) req1_valid = 1'b0;
        end
        chk("both_nresp", nresp, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s0;
        logic       o0, i0;
        bit         got;

        do_reset();

        run_one(0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, "r028");
        chk("r028_cnt", ovf_count, 8'h00);
        run_one(1, 8'h80, 8'h01, 1'b1, X029, 1'b1, "r029");
        chk("r029_cnt", ovf_count, 8'h01);

        do_reset();
        run_both(8'h7F, 8'h01, 1'b0, 8'h10, 8'h20, 1'b1);
        chk("r030_id0", got_id[0], 0);
        chk("r030_s0", got_s[0], X030);
        chk("r030_o0", got_o[0], 1);
        chk("r030_id1", got_id[1], 1);
        chk("r030_s1", got_s[1], 8'hF0);
        chk("r030_o1", got_o[1], 0);
        chk("r030_cnt", ovf_count, 8'h01);

        // Consumer stall in RESP with the other requester waiting.
        @(posedge clk); #1 rsp_ready = 1'b0; drive(0, 8'h01, 8'h01, 1'b0);
        wait_ready(0, got);
        @(posedge clk); #1 req0_valid = 1'b0; drive(1, 8'h22, 8'h11, 1'b1);
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        chk("r031_valid", got, 1);
        s0 = rsp_s; o0 = rsp_ovf; i0 = rsp_id;
        chk("r031_s", s0, 8'h02);
        repeat (4) begin
            @(negedge clk);
            chk("r031_hold_valid", rsp_valid, 1);
            chk("r031_hold_s", rsp_s, s0);
            chk("r031_hold_ovf", rsp_ovf, o0);
            chk("r031_hold_id", rsp_id, i0);
            chk("r031_readys", {req0_ready, req1_ready}, 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("r031_last_valid", rsp_valid, 1);
        @(negedge clk);
        chk("r031_idle_valid", rsp_valid, 0);
        chk("r031_idle_ready1", req1_ready, 1);
        @(posedge clk); #1 req1_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Reset while the operation sits in EXEC.
        do_reset();
        @(posedge clk); #1 drive(1, 8'h7F, 8'h7F, 1'b0);
        wait_ready(1, got);
        @(posedge clk); #1 req1_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("r032_no_valid", rsp_valid, 0);
            chk("r032_cnt", ovf_count, 0);
        end
        run_both(8'h01, 8'h02, 1'b0, 8'h05, 8'h01, 1'b1);
        chk("r032_tie_id0", got_id[0], 0);
        chk("r032_tie_s0", got_s[0], 8'h03);
        chk("r032_tie_id1", got_id[1], 1);
        chk("r032_tie_s1", got_s[1], 8'h04);

        // Saturating overflow counter.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_one(i % 2, 8'h7F, 8'h01, 1'b0, X030, 1'b1, "r033");
            if (i == 253) chk("r033_cnt_fe", ovf_count, 8'hFE);
            if (i == 254) chk("r033_cnt_ff", ovf_count, 8'hFF);
        end
        chk("r033_cnt_hold", ovf_count, 8'hFF);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
